button_gesture_decoder: RTL and testbench

BUTTON_GESTURE_DECODER -- requirements
Module: button_gesture_decoder

---
 rtl/button_gesture_decoder.sv | 118 +++++++++++
 tb/tb_button_gesture_decoder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/button_gesture_decoder.sv
// Classifies debounced button activity into short press, long press, double click and auto-repeat.
// All outputs are registered; a gesture pulse appears one cycle after the deciding input.
module button_gesture_decoder #(
  parameter int CW            = 16,
  parameter int LONG_CYCLES   = 50000,
  parameter int GAP_CYCLES    = 20000,
  parameter int REPEAT_CYCLES = 10000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       PB_pressed_pulse,
  input  logic       PB_released_pulse,
  input  logic       PB_pressed_state,
  output logic       short_press,
  output logic       long_press,
  output logic       double_click,
  output logic       repeat_pulse,
  output logic       busy,
  output logic [7:0] gesture_count
);

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          released;

  // A release is recognised from either the pulse or the debounced level.
  assign released = PB_released_pulse | ~PB_pressed_state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      double_click  <= 1'b0;
      repeat_pulse  <= 1'b0;
      busy          <= 1'b0;
      gesture_count <= 8'd0;
    end else begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      repeat_pulse <= 1'b0;
      cnt          <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

      case (state)
        IDLE: begin
          if (PB_pressed_pulse) begin
            state <= PRESS1;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        PRESS1: begin
          if (released) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state         <= HOLD;
            cnt           <= '0;
            long_press    <= 1'b1;
            gesture_count <= gesture_count + 8'd1;
          end
        end
        WAIT2: begin
          // A press on the final gap cycle still counts as the second click.
          if (PB_pressed_pulse) begin
            state <= PRESS2;
            cnt   <= '0;
          end else if (cnt == GAP_LAST) begin
            state         <= IDLE;
            cnt           <= '0;
            busy          <= 1'b0;
            short_press   <= 1'b1;
            gesture_count <= gesture_count + 8'd1;
          end
        end
        PRESS2: begin
          if (released) begin
            state         <= IDLE;
            cnt           <= '0;
            busy          <= 1'b0;
            double_click  <= 1'b1;
            gesture_count <= gesture_count + 8'd1;
          end else if (cnt == LONG_LAST) begin
            state         <= HOLD;
            cnt           <= '0;
            long_press    <= 1'b1;
            gesture_count <= gesture_count + 8'd1;
          end
        end
        HOLD: begin
          if (released) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == REP_LAST) begin
            cnt          <= '0;
            repeat_pulse <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Scenario table plus hand-written reset and rollover sequences for button_gesture_decoder.
module tb_button_gesture_decoder;

  logic       clock = 1'b0;
  logic       reset;
  logic       PB_pressed_pulse, PB_released_pulse, PB_pressed_state;
  logic       short_press, long_press, double_click, repeat_pulse, busy;
  logic [7:0] gesture_count;

  int total = 0;
  int bad   = 0;

  button_gesture_decoder #(.CW(4), .LONG_CYCLES(8), .GAP_CYCLES(5), .REPEAT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .PB_pressed_pulse(PB_pressed_pulse), .PB_released_pulse(PB_released_pulse),
    .PB_pressed_state(PB_pressed_state),
    .short_press(short_press), .long_press(long_press), .double_click(double_click),
    .repeat_pulse(repeat_pulse), .busy(busy), .gesture_count(gesture_count)
  );

  always #5 clock = ~clock;

  // Scenario: input event cycles and the cycles in which each output is required (-1 = never).
  typedef struct {
    string name;
    int p1, r1, p2, r2, len;
    int e_short, e_long, e_dbl, rep_a, rep_b, busy_lo;
  } vec_t;

  typedef struct {
    string      name;
    int         cyc;
    logic [4:0] pulses;  // short, long, double, repeat, busy
    logic [7:0] gc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic drive(input logic rst, input logic p, input logic r, input logic l);
    @(posedge clock);
    #1;
    reset             = rst;
    PB_pressed_pulse  = p;
    PB_released_pulse = r;
    PB_pressed_state  = l;
  endtask

  task automatic pop_compare();
    exp_t e;
    @(negedge clock);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      total++;
      if ({short_press, long_press, double_click, repeat_pulse, busy} != e.pulses ||
          gesture_count != e.gc) begin
        bad++;
        $display("FAIL %s cyc %0d: got s/l/d/r/b=%b gc=%0d expected %b gc=%0d", e.name, e.cyc,
                 {short_press, long_press, double_click, repeat_pulse, busy}, gesture_count,
                 e.pulses, e.gc);
      end
    end
  endtask

  vec_t vecs[6];
  logic [7:0] gc_base;

  initial begin
    vecs[0] = '{"short",        0,  3, -1, -1, 14,  9, -1, -1, -1, -1,  9};
    vecs[1] = '{"double",       0,  3,  6,  9, 14, -1, -1, 10, -1, -1, 10};
    vecs[2] = '{"long_repeat",  0, 20, -1, -1, 26, -1,  9, -1, 13, 17, 21};
    vecs[3] = '{"long_bound",   0,  8, -1, -1, 18, 14, -1, -1, -1, -1, 14};
    vecs[4] = '{"gap_bound",    0,  3,  8, 10, 15, -1, -1, 11, -1, -1, 11};
    vecs[5] = '{"press2_long",  0,  3,  6, 17, 22, -1, 15, -1, -1, -1, 18};

    reset = 1'b0; PB_pressed_pulse = 1'b0; PB_released_pulse = 1'b0; PB_pressed_state = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_pulses", {short_press, long_press, double_click, repeat_pulse}, 0);
    check("reset_busy", busy, 0);
    check("reset_gc", gesture_count, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    gc_base = 8'd0;
    for (int v = 0; v < 6; v++) begin
      for (int c = 0; c < vecs[v].len; c++) begin
        exp_t e;
        logic lvl;
        lvl = (c >= vecs[v].p1 && c < vecs[v].r1) ||
              (vecs[v].p2 >= 0 && c >= vecs[v].p2 && c < vecs[v].r2);
        drive(1'b1, (c == vecs[v].p1) || (c == vecs[v].p2),
              (c == vecs[v].r1) || (c == vecs[v].r2), lvl);
        e.name = vecs[v].name;
        e.cyc  = c;
        e.pulses = {c == vecs[v].e_short, c == vecs[v].e_long, c == vecs[v].e_dbl,
                    (c == vecs[v].rep_a) || (c == vecs[v].rep_b),
                    (c >= 1) && (c < vecs[v].busy_lo)};
        e.gc = gc_base;
        if (vecs[v].e_short >= 0 && c >= vecs[v].e_short) e.gc = e.gc + 8'd1;
        if (vecs[v].e_long  >= 0 && c >= vecs[v].e_long)  e.gc = e.gc + 8'd1;
        if (vecs[v].e_dbl   >= 0 && c >= vecs[v].e_dbl)   e.gc = e.gc + 8'd1;
        sb.push_back(e);
        pop_compare();
      end
      gc_base = gc_base + 8'd1;
    end
    check("gc_after_table", gesture_count, 6);

    // Reset in cycle 5 of a held press: everything clears, held button is then ignored.
    begin
      int seen_long;
      int seen_busy;
      seen_long = 0;
      seen_busy = 0;
      for (int c = 0; c < 5; c++) drive(1'b1, c == 0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      @(negedge clock);
      check("mid_reset_pulses", {short_press, long_press, double_click, repeat_pulse}, 0);
      check("mid_reset_busy", busy, 0);
      check("mid_reset_gc", gesture_count, 0);
      for (int c = 0; c < 15; c++) begin
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        if (long_press) seen_long++;
        if (busy) seen_busy++;
      end
      check("held_after_reset_long", seen_long, 0);
      check("held_after_reset_busy", seen_busy, 0);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
    end

    // 256 long presses: count reaches 255 then wraps to 0.
    begin
      int longs;
      longs = 0;
      for (int g = 0; g < 256; g++) begin
        for (int c = 0; c < 13; c++) begin
          drive(1'b1, c == 0, c == 10, (c < 10));
          @(negedge clock);
          if (long_press) longs++;
        end
        if (g == 254) check("gc_at_255", gesture_count, 255);
      end
      check("rollover_long_count", longs, 256);
      check("gc_wrapped", gesture_count, 0);
      check("rollover_idle_busy", busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
